// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a 4-byte big-endian word count, packs payload bytes MSB-first
// into 32-bit words and writes them from BASE_ADDR upward. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module imem_loader #(
  parameter int              AW        = 32,
  parameter int              DW        = 32,
  parameter int              MAX_WORDS = 256,
  parameter logic [AW-1:0]   BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          error
);
  localparam int IW = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t        state_q;
  logic [1:0]    byte_cnt_q;
  logic [23:0]   shift_q;
  logic [IW-1:0] word_cnt_q;
  logic [IW-1:0] word_idx_q;
  logic          in_ready_q;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;
  logic          cpu_hold_q;
  logic          busy_q;
  logic          done_q;
  logic          error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    csum_q;
`endif

  logic        accept_d;
  logic [31:0] word_d;
  logic        last_word_d;

  // The shift register is shared: it holds the header first, then each payload word.
  assign accept_d    = in_valid && in_ready_q;
  assign word_d      = {shift_q, in_data};
  assign last_word_d = (word_idx_q == word_cnt_q - IW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      word_cnt_q <= '0;
      word_idx_q <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= BASE_ADDR;
      wr_data_q  <= '0;
      cpu_hold_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_HDR;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
          end
        end
        S_HDR: begin
          if (accept_d) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            shift_q    <= word_d[23:0];
            if (byte_cnt_q == 2'd3) begin
              word_cnt_q <= word_d[IW-1:0];
              if (word_d > 32'(MAX_WORDS)) begin
                state_q    <= S_ERR;
                in_ready_q <= 1'b0;
              end else if (word_d == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_q    <= S_CSUM;
`else
                state_q    <= S_DONE;
                in_ready_q <= 1'b0;
`endif
              end else begin
                state_q <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (accept_d) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            shift_q    <= word_d[23:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_q ^ in_data;
`endif
            if (byte_cnt_q == 2'd3) begin
              wr_en_q    <= 1'b1;
              wr_addr_q  <= BASE_ADDR + (AW'(word_idx_q) << 2);
              wr_data_q  <= word_d;
              word_idx_q <= word_idx_q + IW'(1);
              if (last_word_d) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_q    <= S_CSUM;
`else
                state_q    <= S_DONE;
                in_ready_q <= 1'b0;
`endif
              end
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept_d) begin
            in_ready_q <= 1'b0;
            state_q    <= (in_data == csum_q) ? S_DONE : S_ERR;
          end
        end
`endif
        // Status flags settle one cycle after the final byte so the last write commits first.
        S_DONE: begin
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          cpu_hold_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        S_ERR: begin
          error_q    <= 1'b1;
          busy_q     <= 1'b0;
          cpu_hold_q <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_hold = cpu_hold_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule
